// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file: trap/mret state, 64-bit counters, gated interrupts
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] read_address,
  output logic [31:0] read_data,
  input  logic        csr_write,
  input  logic [11:0] csr_address,
  input  logic [31:0] csr_data,
  input  logic        traped,
  input  logic        mret,
  input  logic        retired,
  input  logic [31:0] ecp,
  input  logic [3:0]  ecause,
  input  logic        interupt,
  input  logic        software_irq,
  input  logic        timer_irq,
  input  logic        external_irq,
  output logic        sip,
  output logic        tip,
  output logic        eip,
  output logic [31:0] trap_vector,
  output logic [31:0] mret_vector
);

  localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA     = 12'h301, A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305, A_MSCRATCH = 12'h340, A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342, A_MIP      = 12'h344, A_MHARTID = 12'hF14;
  localparam logic [11:0] A_MCYCLE   = 12'hB00, A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRET = 12'hB02, A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00, A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTRET  = 12'hC02, A_INSTRETH = 12'hC82;

  logic        status_mie, status_mpie;
  logic        msie, mtie, meie;
  logic [29:0] mtvec_base, mepc_base;
  logic [31:0] mscratch, mcause;
  logic [63:0] mcycle, minstret;

  // trap and mret outrank a software write on the trap-state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mepc_base   <= '0;
      mcause      <= '0;
    end else if (traped) begin
      status_mpie <= status_mie;
      status_mie  <= 1'b0;
      mepc_base   <= ecp[31:2];
      mcause      <= {interupt, 27'b0, ecause};
    end else if (mret) begin
      status_mie  <= status_mpie;
      status_mpie <= 1'b1;
    end else if (csr_write) begin
      case (csr_address)
        A_MSTATUS: begin
          status_mie  <= csr_data[3];
          status_mpie <= csr_data[7];
        end
        A_MEPC:   mepc_base <= csr_data[31:2];
        A_MCAUSE: mcause    <= csr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msie       <= 1'b0;
      mtie       <= 1'b0;
      meie       <= 1'b0;
      mtvec_base <= MTVEC_RESET[31:2];
      mscratch   <= '0;
    end else if (csr_write) begin
      case (csr_address)
        A_MIE: begin
          msie <= csr_data[3];
          mtie <= csr_data[7];
          meie <= csr_data[11];
        end
        A_MTVEC:    mtvec_base <= csr_data[31:2];
        A_MSCRATCH: mscratch   <= csr_data;
        default: ;
      endcase
    end
  end

  // a write to either counter half suppresses that counter's increment for the cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (csr_write && csr_address == A_MCYCLE)        mcycle[31:0]  <= csr_data;
      else if (csr_write && csr_address == A_MCYCLEH)  mcycle[63:32] <= csr_data;
      else                                             mcycle        <= mcycle + 64'd1;

      if (csr_write && csr_address == A_MINSTRET)       minstret[31:0]  <= csr_data;
      else if (csr_write && csr_address == A_MINSTRETH) minstret[63:32] <= csr_data;
      else if (retired)                                 minstret        <= minstret + 64'd1;
    end
  end

  assign sip         = status_mie & msie & software_irq;
  assign tip         = status_mie & mtie & timer_irq;
  assign eip         = status_mie & meie & external_irq;
  assign trap_vector = {mtvec_base, 2'b00};
  assign mret_vector = {mepc_base, 2'b00};

  always_comb begin
    read_data = 32'h0;
    case (read_address)
      A_MSTATUS:              read_data = {19'b0, 2'b11, 3'b0, status_mpie, 3'b0, status_mie, 3'b0};
      A_MISA:                 read_data = 32'h4000_0100;
      A_MIE:                  read_data = {20'b0, meie, 3'b0, mtie, 3'b0, msie, 3'b0};
      A_MTVEC:                read_data = trap_vector;
      A_MSCRATCH:             read_data = mscratch;
      A_MEPC:                 read_data = mret_vector;
      A_MCAUSE:               read_data = mcause;
      A_MIP:                  read_data = {20'b0, external_irq, 3'b0, timer_irq, 3'b0, software_irq, 3'b0};
      A_MCYCLE, A_CYCLE:      read_data = mcycle[31:0];
      A_MCYCLEH, A_CYCLEH:    read_data = mcycle[63:32];
      A_MINSTRET, A_INSTRET:  read_data = minstret[31:0];
      A_MINSTRETH, A_INSTRETH: read_data = minstret[63:32];
      A_MHARTID:              read_data = HART_ID;
      default:                read_data = 32'h0;
    endcase
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode control/status register file at the consuming end of the writeback stage's CSR/trap interface. It accepts CSR writes, trap, mret and retire events from writeback. It updates mstatus/mepc/mcause and the 64-bit cycle/instret counters, and returns gated interrupt requests (sip/tip/eip) to writeback. It also provides a combinational CSR read port for execute and trap/return vectors for fetch.

## Interface
- MTVEC_RESET, 32'h00000000, reset value of mtvec (bits 1:0 forced 0)
- HART_ID, 0, value read from mhartid
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- read_address  input  12  CSR address to read (execute stage)
- read_data  output  32  combinational read value; 0 for unimplemented addresses
- csr_write  input  1  commit CSR write (already gated by writeback)
- csr_address  input  12  write address
- csr_data  input  32  write value
- traped  input  1  trap taken this cycle
- mret  input  1  mret committed this cycle
- retired  input  1  one instruction retired this cycle
- ecp  input  32  exception PC to save
- ecause  input  4  cause code
- interupt  input  1  trap is an interrupt
- software_irq, timer_irq, external_irq  input  1 each  level-sensitive raw interrupt lines
- sip, tip, eip  output  1 each  enabled pending interrupts to writeback
- trap_vector  output  32  mtvec (direct mode only)
- mret_vector  output  32  mepc

## Operation
- Registers and addresses:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP bits 12:11 read 2'b11; other bits read 0.
  - misa 0x301: read-only 32'h40000100 (RV32I).
  - mie 0x304: MSIE bit 3, MTIE bit 7, MEIE bit 11.
  - mtvec 0x305: bits 1:0 read 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits 1:0 read 0.
  - mcause 0x342: full 32 bits.
  - mtval 0x343: reads 0, writes ignored.
  - mip 0x344: read-only; bits 3/7/11 show the raw software/timer/external lines.
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82: writable.
  - cycle/instret/cycleh/instreth 0xC00/0xC02/0xC80/0xC82: read-only aliases.
  - mvendorid/marchid/mimpid 0xF11–0xF13: read 0; mhartid 0xF14 reads HART_ID.
- Writes to read-only or unimplemented addresses are ignored.
- Interrupt gating (combinational from registered state and raw lines):
  - sip = MIE & MSIE & software_irq
  - tip = MIE & MTIE & timer_irq
  - eip = MIE & MEIE & external_irq
- Priority per cycle: traped > mret > csr_write for mstatus, mepc and mcause.
- On traped:
  - mepc <= {ecp[31:2],2'b00}
  - mcause <= {interupt, 27'b0, ecause}
  - MPIE <= MIE; MIE <= 0
- On mret (without traped): MIE <= MPIE; MPIE <= 1.
- On csr_write: the target register takes csr_data, with read-only bits masked.
- Counters (64-bit, wrap 2^64−1 → 0):
  - mcycle increments every cycle.
  - minstret increments when retired=1.
  - A CSR write to either half takes priority: that half loads csr_data and the whole counter skips its increment that cycle.
  - The other half holds its value.

## Timing
- All state updates are visible on read_data, sip/tip/eip and the vectors in the cycle after the edge. There is no bypass of same-cycle writes.
- sip/tip/eip are combinational from raw lines; raw lines must be synchronous to clk. There is no path from traped to sip/tip/eip within a cycle (no loop).
- After a trap, sip/tip/eip are 0 from the next cycle (MIE cleared) until mret or an mstatus write.
- Reset (any time, including mid-trap) applies immediately:
  - mstatus MIE/MPIE = 0; mie = 0; mtvec = MTVEC_RESET & ~3.
  - mscratch, mepc, mcause = 0; mcycle, minstret = 0.
  - Outputs: sip/tip/eip = 0; trap_vector = MTVEC_RESET & ~3; mret_vector = 0.
- Counters resume counting at the first edge after reset deasserts: mcycle reads 1 in the following cycle.

## Test plan
- Reset, then idle 10 cycles → mcycle reads 10 and minstret reads 0; reset mid-run → all counters 0 and sip/tip/eip = 0 immediately.
- Write mstatus=0x8, mie=0x80, raise timer_irq → tip=1 next cycle. Pulse traped with ecp=0x104, ecause=7, interupt=1 → mepc=0x104, mcause=0x80000007, MIE=0, MPIE=1, tip=0.
- Then pulse mret → MIE=1, MPIE=1, tip=1 again while timer_irq is held; mret_vector=0x104.
- Assert csr_write (mstatus=0) and traped in the same cycle → trap update wins; mepc and mcause updated.
- Write mcycle=0xFFFFFFFF, mcycleh=0 → after 1 cycle mcycle=0, mcycleh=1. Write minstret with retired=1 → minstret equals the written value, no increment.
- Write mtvec=0x80000003 → reads 0x80000000, trap_vector=0x80000000. Write 0xC00 or misa → no change. Read 0x7C0 → 0.
